// File: rtl/coin_key_filter_if.sv
// ============================================================================
//  Module      : coin_key_filter_if
//  Description : Key-in / coin-pulse-out bundle between the raw push-buttons
//                and the coin key filter. The master side owns the buttons
//                and consumes the coin pulses; the slave side is the filter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface coin_key_filter_if;
    // Raw active-low push-buttons, asynchronous to sys_clk and free to bounce.
    logic key_one;
    logic key_half;
    // Clean single-cycle coin pulses, never both high in the same cycle.
    logic po_money_one;
    logic po_money_half;

    modport master (
        output key_one,
        output key_half,
        input  po_money_one,
        input  po_money_half
    );

    modport slave (
        input  key_one,
        input  key_half,
        output po_money_one,
        output po_money_half
    );
endinterface

`default_nettype wire

// File: rtl/coin_key_filter.sv
// ============================================================================
//  Module      : coin_key_filter
//  Description : Synchronises and debounces the 1 yuan and 0.5 yuan coin keys
//                and emits one clean pulse per confirmed press. A 1 yuan pulse
//                wins a same-cycle tie; the 0.5 yuan pulse is then held in a
//                one-deep store and issued on the following cycle.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module coin_key_filter #(
    parameter int unsigned CNT_W   = 20,
    parameter int unsigned CNT_MAX = 999_999
) (
    input  wire logic          sys_clk,
    input  wire logic          sys_rst,
    coin_key_filter_if.slave   bus
);

    // Debounce FSM encoding, shared by both key instances.
    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_HELD         = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam int KEY_ONE  = 0;
    localparam int KEY_HALF = 1;

    // Index 0 is the 1 yuan key, index 1 the 0.5 yuan key.
    logic [1:0] key_raw;
    logic [1:0] confirm;

    assign key_raw = {bus.key_half, bus.key_one};

    // ------------------------------------------------------------------------
    // One synchroniser plus debounce FSM per key. The FSM only ever looks at
    // the second synchroniser stage, so a bouncing or metastable raw input
    // cannot reach the counter logic directly.
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < 2; i++) begin : g_key
        logic             k_s1;
        logic             k_s2;
        logic [1:0]       state;
        logic [1:0]       state_next;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_next;
        logic             cnt_done;
        logic             confirm_k;

        assign cnt_done = (cnt == CNT_TOP);

        // Two-flop synchroniser; resets to the released (high) level.
        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                k_s1 <= 1'b1;
                k_s2 <= 1'b1;
            end else begin
                k_s1 <= key_raw[i];
                k_s2 <= k_s1;
            end
        end

        // State register: FSM state and its debounce counter.
        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                state <= ST_IDLE;
                cnt   <= CNT_ZERO;
            end else begin
                state <= state_next;
                cnt   <= cnt_next;
            end
        end

        // Next-state logic: any level change inside a wait window restarts
        // from the previous stable state with a cleared counter.
        always_comb begin
            state_next = state;
            cnt_next   = cnt;
            case (state)
                ST_IDLE: begin
                    if (!k_s2) begin
                        state_next = ST_PRESS_WAIT;
                        cnt_next   = CNT_ZERO;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (k_s2) begin
                        state_next = ST_IDLE;
                        cnt_next   = CNT_ZERO;
                    end else if (cnt_done) begin
                        state_next = ST_HELD;
                        cnt_next   = CNT_ZERO;
                    end else begin
                        cnt_next   = cnt + CNT_ONE;
                    end
                end
                ST_HELD: begin
                    if (k_s2) begin
                        state_next = ST_RELEASE_WAIT;
                        cnt_next   = CNT_ZERO;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (!k_s2) begin
                        state_next = ST_HELD;
                        cnt_next   = CNT_ZERO;
                    end else if (cnt_done) begin
                        state_next = ST_IDLE;
                        cnt_next   = CNT_ZERO;
                    end else begin
                        cnt_next   = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = CNT_ZERO;
                end
            endcase
        end

        // Output logic: the confirm strobe fires on the single cycle that the
        // press window completes, i.e. on the PRESS_WAIT -> HELD transition.
        always_comb begin
            confirm_k = 1'b0;
            if (state == ST_PRESS_WAIT && !k_s2 && cnt_done) begin
                confirm_k = 1'b1;
            end
        end

        assign confirm[i] = confirm_k;
    end

    // ------------------------------------------------------------------------
    // Output arbitration. A 1 yuan confirm always issues immediately; a
    // 0.5 yuan confirm that collides with it is parked in half_pend and goes
    // out on the next cycle. Two half confirms cannot arrive within one
    // debounce window, so a single pending bit never overflows.
    // ------------------------------------------------------------------------
    logic pulse_one;
    logic pulse_half;
    logic half_pend;

    // Registered coin pulses with 1 yuan priority and a one-deep half store.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pulse_one  <= 1'b0;
            pulse_half <= 1'b0;
            half_pend  <= 1'b0;
        end else begin
            pulse_one  <= confirm[KEY_ONE];
            pulse_half <= 1'b0;
            if (confirm[KEY_ONE]) begin
                if (confirm[KEY_HALF]) begin
                    half_pend <= 1'b1;
                end
            end else if (confirm[KEY_HALF] || half_pend) begin
                pulse_half <= 1'b1;
                half_pend  <= 1'b0;
            end
        end
    end

    assign bus.po_money_one  = pulse_one;
    assign bus.po_money_half = pulse_half;

endmodule

`default_nettype wire

// File: tb/tb_coin_key_filter.sv
// ============================================================================
//  Module      : tb_coin_key_filter
//  Description : Directed and random-bounce bench for coin_key_filter with a
//                debounce window of 11 cycles (CNT_MAX = 10).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_coin_key_filter;

    localparam int CNT_MAX = 10;
    // A press is confirmed on the (CNT_MAX+2)-th consecutive synchronised low
    // sample counted from IDLE; a release re-arms after as many high samples.
    localparam int RUN_LEN = CNT_MAX + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    coin_key_filter_if bus ();

    coin_key_filter #(
        .CNT_W   (20),
        .CNT_MAX (CNT_MAX)
    ) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: run-length view of the synchronised keys plus the
    // tie-break rule. Evaluated on every rising edge.
    // ------------------------------------------------------------------
    int   cyc = 0;
    logic m_s1 [2];
    logic m_s2 [2];
    int   m_low [2];
    int   m_high [2];
    logic m_armed [2];
    logic m_pend = 1'b0;
    logic m_exp_one = 1'b0;
    logic m_exp_half = 1'b0;

    initial begin
        logic conf [2];
        logic keys [2];
        forever begin
            @(posedge clk);
            cyc++;
            keys[0] = bus.key_one;
            keys[1] = bus.key_half;
            if (rst) begin
                for (int i = 0; i < 2; i++) begin
                    m_s1[i] = 1'b1; m_s2[i] = 1'b1;
                    m_low[i] = 0;   m_high[i] = 0;
                    m_armed[i] = 1'b1;
                end
                m_pend = 1'b0; m_exp_one = 1'b0; m_exp_half = 1'b0;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    conf[i] = 1'b0;
                    if (!m_s2[i]) begin
                        m_high[i] = 0;
                        m_low[i]++;
                        if (m_armed[i] && m_low[i] == RUN_LEN) begin
                            conf[i] = 1'b1;
                            m_armed[i] = 1'b0;
                        end
                    end else begin
                        m_low[i] = 0;
                        m_high[i]++;
                        if (!m_armed[i] && m_high[i] == RUN_LEN) m_armed[i] = 1'b1;
                    end
                end
                m_exp_one  = conf[0];
                m_exp_half = 1'b0;
                if (conf[0]) begin
                    if (conf[1]) m_pend = 1'b1;
                end else if (conf[1] || m_pend) begin
                    m_exp_half = 1'b1;
                    m_pend = 1'b0;
                end
                for (int i = 0; i < 2; i++) begin
                    m_s2[i] = m_s1[i];
                    m_s1[i] = keys[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output monitor on the falling edge: pulse bookkeeping, overlap count
    // and cycle-exact comparison against the model.
    // ------------------------------------------------------------------
    int n_one = 0;
    int n_half = 0;
    int last_one = -1;
    int last_half = -1;
    int n_overlap = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (bus.po_money_one === 1'b1)  begin n_one++;  last_one  = cyc; end
            if (bus.po_money_half === 1'b1) begin n_half++; last_half = cyc; end
            if (bus.po_money_one === 1'b1 && bus.po_money_half === 1'b1) n_overlap++;
            check_eq("cycle_vs_model", {30'd0, bus.po_money_one, bus.po_money_half},
                     {30'd0, m_exp_one, m_exp_half});
        end
    end

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int t0;
    int b_one;
    int b_half;
    int rem [2];
    logic lvl [2];

    initial begin
        bus.key_one  = 1'b1;
        bus.key_half = 1'b1;
        rst = 1'b1;
        step(3);
        check_eq("reset_po_one",  {31'd0, bus.po_money_one},  0);
        check_eq("reset_po_half", {31'd0, bus.po_money_half}, 0);
        rst = 1'b0;
        step(20);
        check_eq("idle_no_pulse", n_one + n_half, 0);

        // Clean 1 yuan press: pulse on edge 14, no release pulse.
        b_one = n_one; b_half = n_half;
        t0 = cyc; bus.key_one = 1'b0;
        step(50);
        check_eq("clean_one_count", n_one - b_one, 1);
        check_eq("clean_one_edge",  last_one - t0, 14);
        check_eq("clean_one_half0", n_half - b_half, 0);
        bus.key_one = 1'b1;
        step(30);
        check_eq("clean_one_release", n_one - b_one, 1);

        // Press bounce on the 0.5 yuan key, then a stable hold.
        b_half = n_half;
        for (int r = 0; r < 4; r++) begin
            bus.key_half = 1'b0; step(3);
            bus.key_half = 1'b1; step(2);
        end
        t0 = cyc; bus.key_half = 1'b0;
        step(20);
        check_eq("bounce_half_count", n_half - b_half, 1);
        check_eq("bounce_half_edge",  last_half - t0, 14);
        bus.key_half = 1'b1;
        step(30);

        // Release bounce: glitches shorter than the window add nothing.
        b_one = n_one;
        bus.key_one = 1'b0; step(20);
        for (int r = 0; r < 5; r++) begin
            bus.key_one = 1'b1; step(4);
            bus.key_one = 1'b0; step(2);
        end
        bus.key_one = 1'b1; step(30);
        check_eq("release_bounce_count", n_one - b_one, 1);
        t0 = cyc; bus.key_one = 1'b0;
        step(20);
        check_eq("repress_count", n_one - b_one, 2);
        check_eq("repress_edge",  last_one - t0, 14);
        bus.key_one = 1'b1; step(30);

        // Simultaneous press: 1 yuan at N, 0.5 yuan at N+1.
        b_one = n_one; b_half = n_half;
        t0 = cyc; bus.key_one = 1'b0; bus.key_half = 1'b0;
        step(20);
        check_eq("tie_one_edge",  last_one - t0, 14);
        check_eq("tie_half_edge", last_half - t0, 15);
        check_eq("tie_counts", (n_one - b_one) + (n_half - b_half), 2);
        bus.key_one = 1'b1; bus.key_half = 1'b1; step(30);

        // Reset during PRESS_WAIT with the key held throughout.
        b_one = n_one;
        bus.key_one = 1'b0; step(5);
        rst = 1'b1; step(1);
        check_eq("rst_pw_po_one",  {31'd0, bus.po_money_one},  0);
        check_eq("rst_pw_po_half", {31'd0, bus.po_money_half}, 0);
        rst = 1'b0; t0 = cyc;
        step(20);
        check_eq("rst_pw_count", n_one - b_one, 1);
        check_eq("rst_pw_edge",  last_one - t0, 14);
        bus.key_one = 1'b1; step(30);

        // Reset on the cycle a half pulse is pending: it is dropped.
        b_one = n_one; b_half = n_half;
        bus.key_one = 1'b0; bus.key_half = 1'b0;
        step(14);
        check_eq("pend_one_now", {31'd0, bus.po_money_one}, 1);
        rst = 1'b1; bus.key_one = 1'b1; bus.key_half = 1'b1;
        step(1);
        check_eq("pend_dropped_now", {31'd0, bus.po_money_half}, 0);
        rst = 1'b0;
        step(30);
        check_eq("pend_dropped_half", n_half - b_half, 0);
        check_eq("pend_one_count",    n_one - b_one, 1);

        // Random bounce soak, cycle-checked against the model.
        b_one = n_one; b_half = n_half;
        for (int i = 0; i < 2; i++) begin lvl[i] = 1'b1; rem[i] = 0; end
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (rem[i] == 0) begin
                    lvl[i] = ~lvl[i];
                    rem[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 30))
                                                         : int'($urandom_range(1, 8));
                end
                rem[i]--;
            end
            bus.key_one  = lvl[0];
            bus.key_half = lvl[1];
            step(1);
        end
        bus.key_one = 1'b1; bus.key_half = 1'b1;
        step(40);
        check_eq("soak_active", {31'd0, ((n_one - b_one) > 0) && ((n_half - b_half) > 0)}, 1);
        check_eq("overlap_never", n_overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
